// File: rtl/pll_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Width of the shared phase counter: enough for the largest phase length.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// sync2: generic two-flop synchronizer with async active-low reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, lock wait with timeout/retry,
// lock qualification and system reset release. Runs on the reference clock.
// Optional lock-loss/timeout statistics outputs: define PLL_SUPERVISOR_STATS_EN.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state
`ifdef PLL_SUPERVISOR_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt
`endif
);

  localparam int CNT_W   = cnt_width(RST_HOLD, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);

  state_t               r_state, w_nxt_state;
  logic [CNT_W-1:0]     r_cnt, w_nxt_cnt;
  logic [RETRY_W-1:0]   r_retry, w_nxt_retry;
  logic                 r_pll_rst, r_sys_rst_n, r_ready, r_fail;
  logic                 w_lock_s;
  logic                 w_timeout;
  logic                 w_lock_loss;

  sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  // Next-state, counter and retry decisions; soft_reset overrides everything.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 1'b1;
    w_nxt_retry = r_retry;
    w_timeout   = 1'b0;
    w_lock_loss = 1'b0;
    if (soft_reset) begin
      w_nxt_state = ST_HOLD;
      w_nxt_cnt   = '0;
      w_nxt_retry = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_nxt_state = ST_WAIT_LOCK;
            w_nxt_cnt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_nxt_state = ST_STABLE;
            w_nxt_cnt   = '0;
          end else if (r_cnt == TO_LAST) begin
            w_timeout   = 1'b1;
            w_nxt_retry = r_retry + 1'b1;
            w_nxt_cnt   = '0;
            w_nxt_state = (r_retry == RETRY_LAST) ? ST_FAIL : ST_HOLD;
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_nxt_state = ST_WAIT_LOCK;
            w_nxt_cnt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_nxt_state = ST_RUN;
            w_nxt_cnt   = '0;
          end
        end
        ST_RUN: begin
          w_nxt_cnt = '0;
          if (!w_lock_s) begin
            // Lock lost after a good run: restart with a fresh retry budget.
            w_nxt_state = ST_HOLD;
            w_nxt_retry = '0;
            w_lock_loss = 1'b1;
          end
        end
        ST_FAIL: begin
          w_nxt_cnt = '0;
        end
        default: begin
          w_nxt_state = ST_HOLD;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs registered from the next state so
  // they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_retry     <= w_nxt_retry;
      r_pll_rst   <= (w_nxt_state == ST_HOLD) || (w_nxt_state == ST_FAIL);
      r_sys_rst_n <= (w_nxt_state == ST_RUN);
      r_ready     <= (w_nxt_state == ST_RUN);
      r_fail      <= (w_nxt_state == ST_FAIL);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign state     = r_state;

`ifdef PLL_SUPERVISOR_STATS_EN
  logic [7:0] r_lock_loss_cnt;
  logic [7:0] r_timeout_cnt;

  // Saturating event counters; survive soft_reset, cleared by rst_n only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_loss_cnt <= '0;
      r_timeout_cnt   <= '0;
    end else begin
      if (w_lock_loss && (r_lock_loss_cnt != 8'hFF))
        r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
      if (w_timeout && (r_timeout_cnt != 8'hFF))
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
  assign timeout_cnt   = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock
// patterns, compared each cycle against a phase/time-in-phase model.
module tb_pll_lock_supervisor;
  localparam int RH = 4, LT = 20, LS = 8, MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail;
  logic [2:0] state;
`ifdef PLL_SUPERVISOR_STATS_EN
  logic [7:0] lock_loss_cnt, timeout_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: phase (0 hold,1 wait,2 stable,3 run,4 fail), cycles spent in it,
  // timeouts since the budget was last refreshed, and the lock history.
  int   m_ph, m_t, m_tries, m_ll, m_to;
  logic m_s1, m_s2;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_HOLD(RH), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRY(MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_reset (soft_reset),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .state      (state)
`ifdef PLL_SUPERVISOR_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_cnt   (timeout_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_rst(input logic full);
    m_ph = 0; m_t = 0; m_tries = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    if (full) begin m_ll = 0; m_to = 0; end
  endtask

  task automatic model_edge(input logic lk, input logic sr);
    logic ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    if (sr) begin
      m_ph = 0; m_t = 0; m_tries = 0;
    end else begin
      case (m_ph)
        0: begin
          m_t++;
          if (m_t == RH) begin m_ph = 1; m_t = 0; end
        end
        1: begin
          if (ls) begin m_ph = 2; m_t = 0; end
          else begin
            m_t++;
            if (m_t == LT) begin
              m_tries++;
              if (m_to < 255) m_to++;
              m_ph = (m_tries >= MR) ? 4 : 0;
              m_t = 0;
            end
          end
        end
        2: begin
          if (!ls) begin m_ph = 1; m_t = 0; end
          else begin
            m_t++;
            if (m_t == LS) begin m_ph = 3; m_t = 0; end
          end
        end
        3: begin
          if (!ls) begin
            m_ph = 0; m_t = 0; m_tries = 0;
            if (m_ll < 255) m_ll++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk_all();
    logic [6:0] exp;
    exp = {(m_ph == 0 || m_ph == 4), (m_ph == 3), (m_ph == 3), (m_ph == 4), 3'(m_ph)};
    chk("outputs{pll_rst,sys_rst_n,ready,fail,state}",
        32'({pll_rst, sys_rst_n, ready, fail, state}), 32'(exp));
`ifdef PLL_SUPERVISOR_STATS_EN
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_ll));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
`endif
  endtask

  task automatic step(input logic lk, input logic sr);
    pll_locked = lk;
    soft_reset = sr;
    @(posedge clk);
    model_edge(lk, sr);
    cyc++;
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    soft_reset = 1'b0;
    pll_locked = 1'b0;
    model_rst(1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'({pll_rst, sys_rst_n, ready, fail, state}), 32'(7'b1000000));
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Scenario 1: lock raised at cycle 10, RUN at cycle 21.
    do_reset();
    for (int i = 1; i <= 22; i++) begin
      step(i >= 11, 1'b0);
      if (cyc == 3)  chk("s1_pll_rst_hold", 32'(pll_rst), 32'(1));
      if (cyc == 4)  chk("s1_pll_rst_low", 32'(pll_rst), 32'(0));
      if (cyc == 20) chk("s1_sys_rst_pre", 32'(sys_rst_n), 32'(0));
      if (cyc == 21) begin
        chk("s1_sys_rst_n", 32'(sys_rst_n), 32'(1));
        chk("s1_ready", 32'(ready), 32'(1));
        chk("s1_state_run", 32'(state), 32'(3));
      end
    end

    // Scenario 5: lock loss in RUN; sys_rst_n falls 3 cycles later, re-lock.
    step(1'b0, 1'b0);
    chk("s5_sys_1", 32'(sys_rst_n), 32'(1));
    step(1'b0, 1'b0);
    chk("s5_sys_2", 32'(sys_rst_n), 32'(1));
    step(1'b0, 1'b0);
    chk("s5_sys_fall", 32'(sys_rst_n), 32'(0));
    chk("s5_pll_rst", 32'(pll_rst), 32'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("s5_pll_rst_4th", 32'(pll_rst), 32'(1));
    step(1'b1, 1'b0);
    chk("s5_pll_rst_rel", 32'(pll_rst), 32'(0));
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
    chk("s5_relock_run", 32'(state), 32'(3));
`ifdef PLL_SUPERVISOR_STATS_EN
    chk("s5_lock_loss_cnt", 32'(lock_loss_cnt), 32'(1));
`endif

    // Scenario 2: no lock -> two timeouts, then FAIL forever.
    do_reset();
    for (int i = 1; i <= 80; i++) begin
      step(1'b0, 1'b0);
      if (cyc == 23) chk("s2_wait", 32'(state), 32'(1));
      if (cyc == 24) chk("s2_retry_hold", 32'(pll_rst), 32'(1));
      if (cyc == 27) chk("s2_hold_end", 32'(pll_rst), 32'(1));
      if (cyc == 28) chk("s2_rel_again", 32'(pll_rst), 32'(0));
      if (cyc == 47) chk("s2_fail_pre", 32'(fail), 32'(0));
      if (cyc == 48) chk("s2_fail", 32'({fail, state}), 32'(4'b1100));
      if (cyc == 80) chk("s2_fail_stuck", 32'({pll_rst, state}), 32'(4'b1100));
    end
`ifdef PLL_SUPERVISOR_STATS_EN
    chk("s2_timeout_cnt", 32'(timeout_cnt), 32'(2));
`endif

    // Scenario 3: soft_reset out of FAIL, then normal lock.
    step(1'b0, 1'b1);
    chk("s3_fail_clr", 32'({fail, state}), 32'(4'b0000));
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
    chk("s3_run", 32'(state), 32'(3));

    // Scenario 4: 5-cycle lock blip, drop, then steady lock.
    step(1'b1, 1'b1);
    for (int i = 1; i <= 25; i++) begin
      step((i >= 7 && i <= 11) || (i >= 15), 1'b0);
      if (i == 9)  chk("s4_stable1", 32'(state), 32'(2));
      if (i == 14) chk("s4_back_wait", 32'(state), 32'(1));
      if (i == 17) chk("s4_stable2", 32'(state), 32'(2));
      if (i == 24) chk("s4_not_yet", 32'(state), 32'(2));
      if (i == 25) chk("s4_run", 32'(state), 32'(3));
    end

    // Scenario 6: asynchronous rst_n in the middle of STABLE.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("s6_in_stable", 32'(state), 32'(2));
    #2;
    rst_n = 1'b0;
    model_rst(1'b1);
    #1;
    chk("s6_async_rst", 32'({pll_rst, sys_rst_n, ready, fail, state}), 32'(7'b1000000));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    chk("s6_restart_run", 32'(state), 32'(3));

    // Random lock patterns with occasional soft_reset.
    for (int r = 0; r < 40; r++) begin
      int   len;
      logic lk;
      len = int'($urandom_range(1, 30));
      lk  = logic'($urandom_range(0, 2) != 0);
      for (int i = 0; i < len; i++)
        step(lk, logic'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
